// File: rtl/usb_sof_timer.sv
`default_nettype none
// ============================================================================
//  Module   : usb_sof_timer
//  Purpose  : Locks a local frame timer to received USB SOF strobes, measures
//             the frame period, and keeps producing frame ticks (holdover)
//             when SOFs go missing.
//  Options  : define USB_SOF_TIMER_AVG_EN to smooth period updates in LOCKED
//             with a 1/8 first-order filter instead of loading each sample.
//  Revision : 1.0 - initial release
// ============================================================================
module usb_sof_timer #(
    parameter int NOM_PERIOD = 48000,
    parameter int TOL        = 480,
    parameter int LOCK_CNT   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sof_i,
    input  logic        usb_reset_i,
    output logic        tick_o,
    output logic [15:0] period_o,
    output logic [10:0] frame_cnt_o,
    output logic [7:0]  miss_cnt_o,
    output logic        lock_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        S_HUNT     = 2'd0,
        S_LOCKED   = 2'd1,
        S_HOLDOVER = 2'd2
    } state_t;

    localparam logic [15:0] C_NOM  = 16'(NOM_PERIOD);
    localparam logic [16:0] C_TOL  = 17'(TOL);
    localparam logic [3:0]  C_LOCK = 4'(LOCK_CNT);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] r_ph, w_ph_nxt;
    logic [15:0] r_period, w_period_nxt;
    logic [3:0]  r_good, w_good_nxt;
    logic        r_prev, w_prev_nxt;
    logic        r_tick, w_tick_nxt;
    logic [10:0] r_frame;
    logic [7:0]  r_miss;
    logic        w_miss_inc;
    logic        w_sof;
    logic [15:0] w_dev;
    logic        w_valid;
    logic        w_thresh;
    logic [15:0] w_upd_period;

    // A SOF seen during bus reset is discarded entirely
    assign w_sof    = sof_i & ~usb_reset_i;
    assign w_dev    = (r_cnt >= C_NOM) ? (r_cnt - C_NOM) : (C_NOM - r_cnt);
    assign w_valid  = r_prev & ({1'b0, w_dev} <= C_TOL);
    assign w_thresh = ({1'b0, r_cnt} == ({1'b0, r_period} + C_TOL));

`ifdef USB_SOF_TIMER_AVG_EN
    logic signed [16:0] w_avg_diff;
    logic signed [16:0] w_avg_sum;
    assign w_avg_diff = $signed({1'b0, r_cnt}) - $signed({1'b0, r_period});
    assign w_avg_sum  = $signed({1'b0, r_period}) + (w_avg_diff >>> 3);
    // The filtered value always lies between period and sample, so bit 16
    // stays clear; holding the old period is a safe fallback if it ever set.
    assign w_upd_period = w_avg_sum[16] ? r_period : w_avg_sum[15:0];
`else
    assign w_upd_period = r_cnt;
`endif

    // Next-state, period tracking and tick/miss generation
    always_comb begin
        w_state_nxt  = r_state;
        w_good_nxt   = r_good;
        w_prev_nxt   = r_prev;
        w_period_nxt = r_period;
        w_ph_nxt     = r_ph;
        w_tick_nxt   = 1'b0;
        w_miss_inc   = 1'b0;
        if (usb_reset_i) begin
            w_state_nxt  = S_HUNT;
            w_good_nxt   = 4'd0;
            w_prev_nxt   = 1'b0;
            w_period_nxt = C_NOM;
        end else begin
            if (w_sof) begin
                w_tick_nxt = 1'b1;
                w_prev_nxt = 1'b1;
            end
            case (r_state)
                S_HUNT: begin
                    w_period_nxt = C_NOM;
                    if (w_sof) begin
                        if (w_valid) begin
                            w_good_nxt = r_good + 4'd1;
                            if ((r_good + 4'd1) == C_LOCK) begin
                                w_state_nxt  = S_LOCKED;
                                w_period_nxt = r_cnt;
                            end
                        end else begin
                            w_good_nxt = 4'd0;
                        end
                    end
                end
                S_LOCKED: begin
                    if (w_sof) begin
                        if (w_valid) begin
                            w_period_nxt = w_upd_period;
                        end else begin
                            w_state_nxt  = S_HUNT;
                            w_good_nxt   = 4'd0;
                            w_period_nxt = C_NOM;
                        end
                    end else if (w_thresh) begin
                        w_state_nxt = S_HOLDOVER;
                        w_tick_nxt  = 1'b1;
                        w_miss_inc  = 1'b1;
                        w_ph_nxt    = 16'd1;
                    end
                end
                S_HOLDOVER: begin
                    // A SOF only realigns; its interval is not a sample
                    if (w_sof) begin
                        w_state_nxt = S_LOCKED;
                    end else if (r_ph == r_period) begin
                        w_ph_nxt   = 16'd1;
                        w_tick_nxt = 1'b1;
                        w_miss_inc = 1'b1;
                    end else begin
                        w_ph_nxt = r_ph + 16'd1;
                    end
                end
                default: begin
                    w_state_nxt = S_HUNT;
                end
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_HUNT;
            r_good   <= 4'd0;
            r_prev   <= 1'b0;
            r_period <= C_NOM;
            r_ph     <= 16'd0;
            r_tick   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_good   <= w_good_nxt;
            r_prev   <= w_prev_nxt;
            r_period <= w_period_nxt;
            r_ph     <= w_ph_nxt;
            r_tick   <= w_tick_nxt;
        end
    end

    // Interval counter plus frame and miss counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 16'd0;
            r_frame <= 11'd0;
            r_miss  <= 8'd0;
        end else begin
            if (w_sof) begin
                r_cnt <= 16'd1;
            end else if (r_cnt != 16'hFFFF) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (usb_reset_i) begin
                r_frame <= 11'd0;
                r_miss  <= 8'd0;
            end else begin
                if (w_tick_nxt) begin
                    r_frame <= r_frame + 11'd1;
                end
                if (w_miss_inc && (r_miss != 8'hFF)) begin
                    r_miss <= r_miss + 8'd1;
                end
            end
        end
    end

    assign tick_o      = r_tick;
    assign period_o    = r_period;
    assign frame_cnt_o = r_frame;
    assign miss_cnt_o  = r_miss;
    assign lock_o      = (r_state != S_HUNT);
    assign state_o     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_usb_sof_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_usb_sof_timer
//  Purpose  : Self-checking bench for usb_sof_timer with a small frame period
//             and an event-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_usb_sof_timer;

    localparam int NOM  = 24;
    localparam int TOL  = 8;
    localparam int LOCK = 4;
`ifdef USB_SOF_TIMER_AVG_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sof_i = 1'b0;
    logic        usb_reset_i = 1'b0;
    logic        tick_o;
    logic [15:0] period_o;
    logic [10:0] frame_cnt_o;
    logic [7:0]  miss_cnt_o;
    logic        lock_o;
    logic [1:0]  state_o;
    logic [38:0] act;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: frame-level bookkeeping
    int m_state, m_good, m_period, m_frame, m_miss, m_since, m_age;
    bit m_prev, m_tick;

    bit q_sof[$];
    bit q_ur[$];

    usb_sof_timer #(.NOM_PERIOD(NOM), .TOL(TOL), .LOCK_CNT(LOCK)) dut (
        .clk(clk), .rst(rst), .sof_i(sof_i), .usb_reset_i(usb_reset_i),
        .tick_o(tick_o), .period_o(period_o), .frame_cnt_o(frame_cnt_o),
        .miss_cnt_o(miss_cnt_o), .lock_o(lock_o), .state_o(state_o)
    );

    assign act = {tick_o, period_o, frame_cnt_o, miss_cnt_o, lock_o, state_o};

    always #5 clk = ~clk;

    function automatic logic [38:0] exp_vec();
        return {m_tick, 16'(m_period), 11'(m_frame), 8'(m_miss),
                (m_state != 0), 2'(m_state)};
    endfunction

    function automatic int floor_div8(input int d);
        if (d >= 0) return d / 8;
        return -((-d + 7) / 8);
    endfunction

    task automatic model_reset();
        m_state = 0; m_good = 0; m_prev = 0; m_period = NOM; m_frame = 0;
        m_miss = 0; m_tick = 0; m_since = 0; m_age = 0;
    endtask

    task automatic model_edge(input bit sof, input bit ur);
        int  sample;
        bit  valid;
        bit  t;
        t = 0;
        if (ur) begin
            m_state = 0; m_good = 0; m_prev = 0; m_frame = 0; m_miss = 0;
            m_period = NOM; m_tick = 0;
            if (m_since < 65535) m_since++;
            return;
        end
        if (sof) begin
            sample = m_since;
            valid  = m_prev && (sample - NOM <= TOL) && (NOM - sample <= TOL);
            t = 1;
            if (m_state == 0) begin
                if (valid) begin
                    m_good++;
                    if (m_good == LOCK) begin
                        m_state = 1;
                        m_period = sample;
                    end
                end else begin
                    m_good = 0;
                end
            end else if (m_state == 1) begin
                if (valid) begin
                    m_period = AVG ? m_period + floor_div8(sample - m_period) : sample;
                end else begin
                    m_state = 0; m_good = 0; m_period = NOM;
                end
            end else begin
                m_state = 1;
            end
            m_prev = 1;
            m_since = 1;
        end else begin
            if (m_state == 1 && m_since == m_period + TOL) begin
                m_state = 2; m_age = 0; t = 1;
                if (m_miss < 255) m_miss++;
            end else if (m_state == 2) begin
                m_age++;
                if (m_age % m_period == 0) begin
                    t = 1;
                    if (m_miss < 255) m_miss++;
                end
            end
            if (m_since < 65535) m_since++;
        end
        m_tick = t;
        if (t) m_frame = (m_frame + 1) % 2048;
    endtask

    task automatic step(input bit sof, input bit ur);
        sof_i = sof;
        usb_reset_i = ur;
        @(posedge clk);
        model_edge(sof, ur);
        #1;
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) begin q_sof.push_back(1'b0); q_ur.push_back(1'b0); end
    endtask

    task automatic add_sof_gap(input int gap);
        add_idle(gap - 1);
        q_sof.push_back(1'b1);
        q_ur.push_back(1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        vectors++;
        if (act !== {1'b0, 16'(NOM), 11'd0, 8'd0, 1'b0, 2'd0}) begin
            miscompares++;
            $display("FAIL reset_values: got %h want %h", act, {1'b0, 16'(NOM), 11'd0, 8'd0, 1'b0, 2'd0});
        end
        rst = 1'b0;
    endtask

    task automatic test_lock();
        add_sof_gap(7);
        for (int i = 0; i < 4; i++) add_sof_gap(NOM);
        while (q_sof.size() > 0) begin
            step(q_sof.pop_front(), q_ur.pop_front());
            vectors++;
            if (act !== exp_vec()) begin
                miscompares++;
                $display("FAIL lock_seq: got %h want %h", act, exp_vec());
            end
        end
        vectors++;
        if ({tick_o, state_o, lock_o, period_o, frame_cnt_o} !== {1'b1, 2'd1, 1'b1, 16'(NOM), 11'd5}) begin
            miscompares++;
            $display("FAIL lock_final: got %h want %h", {tick_o, state_o, lock_o, period_o, frame_cnt_o},
                     {1'b1, 2'd1, 1'b1, 16'(NOM), 11'd5});
        end
    endtask

    task automatic test_holdover();
        localparam int N = 50000;
        int exp_frame;
        exp_frame = (5 + 1 + (N - (NOM + TOL)) / NOM) % 2048;
        add_idle(N);
        while (q_sof.size() > 0) begin
            step(q_sof.pop_front(), q_ur.pop_front());
            vectors++;
            if (act !== exp_vec()) begin
                miscompares++;
                $display("FAIL holdover: got %h want %h", act, exp_vec());
            end
        end
        vectors++;
        if ({state_o, lock_o, miss_cnt_o, frame_cnt_o} !== {2'd2, 1'b1, 8'd255, 11'(exp_frame)}) begin
            miscompares++;
            $display("FAIL holdover_sat_wrap: got %h want %h", {state_o, lock_o, miss_cnt_o, frame_cnt_o},
                     {2'd2, 1'b1, 8'd255, 11'(exp_frame)});
        end
        step(1'b1, 1'b0);
        vectors++;
        if ({tick_o, state_o, period_o} !== {1'b1, 2'd1, 16'(NOM)}) begin
            miscompares++;
            $display("FAIL holdover_resume: got %h want %h", {tick_o, state_o, period_o}, {1'b1, 2'd1, 16'(NOM)});
        end
        step(1'b0, 1'b1);
        vectors++;
        if (act !== {1'b0, 16'(NOM), 11'd0, 8'd0, 1'b0, 2'd0}) begin
            miscompares++;
            $display("FAIL usb_reset_clear: got %h want %h", act, {1'b0, 16'(NOM), 11'd0, 8'd0, 1'b0, 2'd0});
        end
    endtask

    task automatic test_early();
        add_sof_gap(3);
        for (int i = 0; i < 4; i++) add_sof_gap(NOM);
        add_sof_gap(NOM - TOL - 2);
        while (q_sof.size() > 0) begin
            step(q_sof.pop_front(), q_ur.pop_front());
            vectors++;
            if (act !== exp_vec()) begin
                miscompares++;
                $display("FAIL early_seq: got %h want %h", act, exp_vec());
            end
        end
        vectors++;
        if ({tick_o, state_o, lock_o, period_o} !== {1'b1, 2'd0, 1'b0, 16'(NOM)}) begin
            miscompares++;
            $display("FAIL early_hunt: got %h want %h", {tick_o, state_o, lock_o, period_o}, {1'b1, 2'd0, 1'b0, 16'(NOM)});
        end
    endtask

    task automatic test_avg();
        int exp_p[3];
        int gaps[3];
        gaps = '{NOM + TOL, NOM + TOL, NOM - TOL};
        if (AVG) exp_p = '{NOM + 1, NOM + 1, NOM - 1};
        else     exp_p = '{NOM + TOL, NOM + TOL, NOM - TOL};
        for (int i = 0; i < 4; i++) add_sof_gap(NOM);
        while (q_sof.size() > 0) begin
            step(q_sof.pop_front(), q_ur.pop_front());
            vectors++;
            if (act !== exp_vec()) begin
                miscompares++;
                $display("FAIL avg_lock: got %h want %h", act, exp_vec());
            end
        end
        for (int k = 0; k < 3; k++) begin
            add_sof_gap(gaps[k]);
            while (q_sof.size() > 0) begin
                step(q_sof.pop_front(), q_ur.pop_front());
                vectors++;
                if (act !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL avg_seq: got %h want %h", act, exp_vec());
                end
            end
            vectors++;
            if ({state_o, period_o} !== {2'd1, 16'(exp_p[k])}) begin
                miscompares++;
                $display("FAIL avg_period%0d: got %0d want %0d", k, period_o, exp_p[k]);
            end
        end
    endtask

    task automatic test_random();
        int gap;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(9) < 7) gap = $urandom_range(NOM + TOL + 2, NOM - TOL - 2);
            else                       gap = $urandom_range(NOM * 4, 1);
            add_sof_gap(gap);
            if ($urandom_range(40) == 0) begin
                q_sof.push_back(1'($urandom_range(1)));
                q_ur.push_back(1'b1);
            end
        end
        while (q_sof.size() > 0) begin
            step(q_sof.pop_front(), q_ur.pop_front());
            vectors++;
            if (act !== exp_vec()) begin
                miscompares++;
                $display("FAIL random: got %h want %h", act, exp_vec());
            end
        end
    endtask

    task automatic test_rst_mid_holdover();
        step(1'b0, 1'b1);
        add_sof_gap(2);
        for (int i = 0; i < 4; i++) add_sof_gap(NOM);
        add_idle(NOM * 3);
        while (q_sof.size() > 0) begin
            step(q_sof.pop_front(), q_ur.pop_front());
            vectors++;
            if (act !== exp_vec()) begin
                miscompares++;
                $display("FAIL rst_setup: got %h want %h", act, exp_vec());
            end
        end
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        vectors++;
        if (act !== {1'b0, 16'(NOM), 11'd0, 8'd0, 1'b0, 2'd0}) begin
            miscompares++;
            $display("FAIL rst_async: got %h want %h", act, {1'b0, 16'(NOM), 11'd0, 8'd0, 1'b0, 2'd0});
        end
        rst = 1'b0;
        add_idle(NOM * 4);
        add_sof_gap(1);
        while (q_sof.size() > 0) begin
            step(q_sof.pop_front(), q_ur.pop_front());
            vectors++;
            if (act !== exp_vec()) begin
                miscompares++;
                $display("FAIL rst_after: got %h want %h", act, exp_vec());
            end
        end
        vectors++;
        if ({tick_o, state_o, frame_cnt_o} !== {1'b1, 2'd0, 11'd1}) begin
            miscompares++;
            $display("FAIL rst_first_tick: got %h want %h", {tick_o, state_o, frame_cnt_o}, {1'b1, 2'd0, 11'd1});
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_holdover();
        test_early();
        test_avg();
        test_random();
        test_rst_mid_holdover();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usb_sof_timer.md
USB_SOF_TIMER -- requirements
Module: usb_sof_timer

Interface
REQ-001 Parameter NOM_PERIOD, default 48000, nominal frame period in clk cycles; SHALL satisfy NOM_PERIOD+TOL <= 65535.
REQ-002 Parameter TOL, default 480, accepted deviation from NOM_PERIOD in cycles.
REQ-003 Parameter LOCK_CNT, default 4, consecutive valid samples needed to lock (1..15).
REQ-004 clk  input  1  the block's only clock; all logic is synchronous to its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 sof_i  input  1  one-cycle strobe per received SOF, driven by the USB core sof output.
REQ-007 usb_reset_i  input  1  level; USB bus reset in progress.
REQ-008 tick_o  output  1  one-cycle frame tick.
REQ-009 period_o  output  16  current frame period estimate in cycles.
REQ-010 frame_cnt_o  output  11  local frame counter.
REQ-011 miss_cnt_o  output  8  count of missed SOFs.
REQ-012 lock_o  output  1  high in LOCKED or HOLDOVER.
REQ-013 state_o  output  2  HUNT=0, LOCKED=1, HOLDOVER=2.

Function
REQ-014 Cycle counter cnt (16 bit) SHALL load 1 on any sof_i cycle, else increment, saturating at 65535; sample = cnt on a sof_i cycle.
REQ-015 A sample SHALL be valid iff a previous SOF was seen since reset/usb_reset_i and |sample-NOM_PERIOD| <= TOL; the first SOF is never a sample.
REQ-016 HUNT: tick_o SHALL pulse the cycle after each sof_i; period_o held at NOM_PERIOD; valid sample increments good_cnt, invalid clears it; when good_cnt reaches LOCK_CNT go to LOCKED and load period_o <= that sample.
REQ-017 LOCKED: tick_o SHALL pulse the cycle after each sof_i; valid sample updates period_o per REQ-024; invalid sample (early/late) SHALL return to HUNT with good_cnt=0.
REQ-018 LOCKED: when cnt reaches period_o+TOL with no sof_i, SHALL enter HOLDOVER, increment miss_cnt_o, pulse tick_o next cycle, load phase counter ph=1.
REQ-019 HOLDOVER: ph increments each cycle; when ph == period_o, ph<=1, tick_o pulses next cycle, miss_cnt_o increments.
REQ-020 HOLDOVER: sof_i SHALL return to LOCKED, realign (tick next cycle, cnt<=1), and SHALL NOT be used as a period sample.
REQ-021 miss_cnt_o SHALL saturate at 255; frame_cnt_o SHALL increment on every tick_o, wrapping 2047->0.
REQ-022 usb_reset_i high SHALL, each cycle, force HUNT, clear good_cnt, the previous-SOF flag, frame_cnt_o, miss_cnt_o, set period_o=NOM_PERIOD, and suppress tick_o; sof_i coinciding with usb_reset_i is ignored.
REQ-023 Simultaneous sof_i and holdover-entry threshold in LOCKED: sof_i wins, no miss counted.

Configuration
REQ-024 Macro USB_SOF_TIMER_AVG_EN defined: in LOCKED a valid sample SHALL update period_o <= period_o + ((sample-period_o) >>> 3), 17-bit signed arithmetic, shift rounds toward minus infinity; undefined: period_o <= sample; lock entry always loads sample directly.

Reset
REQ-025 rst SHALL asynchronously force state HUNT, tick_o=0, period_o=NOM_PERIOD, frame_cnt_o=0, miss_cnt_o=0, lock_o=0, cnt=0, ph=0, good_cnt=0, previous-SOF flag clear.
REQ-026 rst asserted mid-HOLDOVER or mid-lock sequence SHALL abandon it with no further tick_o until the next sof_i after release.

Verification
REQ-027 Five sof_i every 48000 cycles -> tick_o after each, LOCKED after 5th SOF (4 samples), period_o=48000, lock_o=1.
REQ-028 Locked, then SOFs stop -> HOLDOVER at cnt=48480, ticks at +1 then every 48000, miss_cnt_o=1,2,3...; SOF resumes -> LOCKED, tick 1 cycle later.
REQ-029 Locked, SOF arrives after 40000 cycles -> HUNT, state_o=0, period_o=48000.
REQ-030 Locked at 48000, samples of 48080 with AVG_EN -> period_o 48010, 48018...; without -> 48080.
REQ-031 HOLDOVER with 300 misses -> miss_cnt_o=255; usb_reset_i pulse -> HUNT, miss_cnt_o=0, frame_cnt_o=0.
REQ-032 2048 ticks -> frame_cnt_o wraps to 0; rst mid-HOLDOVER -> all outputs at REQ-025 values immediately.
